// File: rtl/roulette_bet_settle_pkg.sv
// Shared definitions for the roulette settlement stage.
// Covers the FSM state encoding, bet kinds and payout multipliers.
package roulette_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_SETTLE = 2'd2,
        S_SHOW   = 2'd3
    } state_e;

    localparam logic BET_SINGLE = 1'b0;
    localparam logic BET_PARITY = 1'b1;

    // Payouts are powers of two, so they are applied as left shifts of the stake.
    localparam int SINGLE_SHIFT = 3;
    localparam int PARITY_SHIFT = 1;

endpackage

// File: rtl/roulette_bet_settle_if.sv
// Bet/spinner/display bundle of the settlement stage.
// The slave side is the settlement block; the master side is the game around it.
interface roulette_bet_settle_if #(
    parameter int CREDIT_W = 16
);
    logic                bet_valid;
    logic                bet_type;
    logic [2:0]          bet_pos;
    logic [7:0]          bet_amount;
    logic [2:0]          result_pos;
    logic                spin_done;
    logic                spin_req;
    logic                bet_reject;
    logic                bet_locked;
    logic [CREDIT_W-1:0] credit;
    logic                win;
    logic [CREDIT_W-1:0] win_amount;
    logic                result_valid;
    logic [2:0]          shown_pos;
    logic                game_over;

    modport master (
        output bet_valid, bet_type, bet_pos, bet_amount, result_pos, spin_done,
        input  spin_req, bet_reject, bet_locked, credit, win, win_amount,
               result_valid, shown_pos, game_over
    );

    modport slave (
        input  bet_valid, bet_type, bet_pos, bet_amount, result_pos, spin_done,
        output spin_req, bet_reject, bet_locked, credit, win, win_amount,
               result_valid, shown_pos, game_over
    );
endinterface

// File: rtl/roulette_bet_settle_bet_judge.sv
// Combinational win/lose decision and payout for one latched bet.
// Payout is the stake zero-extended to credit width, then shifted.
module bet_judge
    import roulette_pkg::*;
#(
    parameter int CREDIT_W = 16
) (
    input  logic                bet_type_i,
    input  logic [2:0]          bet_pos_i,
    input  logic [2:0]          result_i,
    input  logic [7:0]          stake_i,
    output logic                hit_o,
    output logic [CREDIT_W-1:0] payout_o
);
    logic [CREDIT_W-1:0] stake_ext;

    assign stake_ext = CREDIT_W'(stake_i);

    always_comb begin
        if (bet_type_i == BET_SINGLE) begin
            hit_o    = (result_i == bet_pos_i);
            payout_o = stake_ext << SINGLE_SHIFT;
        end else begin
            hit_o    = (result_i[0] == bet_pos_i[0]);
            payout_o = stake_ext << PARITY_SHIFT;
        end
    end
endmodule

// File: rtl/roulette_bet_settle.sv
// Roulette settlement: takes a bet, debits it, requests a spin, judges the result,
// credits the payout (saturating) and holds the result on display for SHOW_CYCLES.
module roulette_bet_settle
    import roulette_pkg::*;
#(
    parameter int INIT_CREDIT = 100,
    parameter int CREDIT_W    = 16,
    parameter int SHOW_CYCLES = 50_000_000
) (
    input logic                 clk,
    input logic                 rst,
    roulette_bet_settle_if.slave bus
);
    localparam int HOLD_W = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};
    localparam logic [CREDIT_W-1:0] CREDIT_RST = CREDIT_W'(INIT_CREDIT);
    localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(SHOW_CYCLES - 1);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                bet_type_q;
    logic [2:0]          bet_pos_q;
    logic [7:0]          stake_q;
    logic [2:0]          shown_pos_q;
    logic                win_q;
    logic [CREDIT_W-1:0] win_amount_q;
    logic                spin_req_q;
    logic                bet_reject_q;
    logic                result_valid_q;
    logic                bet_locked_q;
    logic                game_over_q;
    logic [HOLD_W-1:0]   hold_cnt_q;

    logic                hit;
    logic [CREDIT_W-1:0] payout;
    logic [CREDIT_W-1:0] stake_ext;
    logic                accept;
    logic [CREDIT_W:0]   credit_sum;
    logic [CREDIT_W-1:0] credit_won;

    bet_judge #(
        .CREDIT_W (CREDIT_W)
    ) u_bet_judge (
        .bet_type_i (bet_type_q),
        .bet_pos_i  (bet_pos_q),
        .result_i   (shown_pos_q),
        .stake_i    (stake_q),
        .hit_o      (hit),
        .payout_o   (payout)
    );

    always_comb begin
        stake_ext  = CREDIT_W'(bus.bet_amount);
        accept     = bus.bet_valid && (bus.bet_amount != 8'd0) && (stake_ext <= credit_q);
        // One extra bit catches the carry so the win can clamp instead of wrapping.
        credit_sum = {1'b0, credit_q} + {1'b0, payout};
        credit_won = credit_sum[CREDIT_W] ? CREDIT_MAX : credit_sum[CREDIT_W-1:0];
        state_d    = state_q;
        credit_d   = credit_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d  = S_ARMED;
                    credit_d = credit_q - stake_ext;
                end
            end
            S_ARMED: begin
                if (bus.spin_done) state_d = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = S_SHOW;
                if (hit) credit_d = credit_won;
            end
            S_SHOW: begin
                if (hold_cnt_q == HOLD_LAST) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            credit_q       <= CREDIT_RST;
            bet_type_q     <= 1'b0;
            bet_pos_q      <= '0;
            stake_q        <= '0;
            shown_pos_q    <= '0;
            win_q          <= 1'b0;
            win_amount_q   <= '0;
            spin_req_q     <= 1'b0;
            bet_reject_q   <= 1'b0;
            result_valid_q <= 1'b0;
            bet_locked_q   <= 1'b0;
            game_over_q    <= 1'b0;
            hold_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            spin_req_q     <= 1'b0;
            bet_reject_q   <= 1'b0;
            result_valid_q <= 1'b0;
            bet_locked_q   <= (state_d != S_IDLE);
            game_over_q    <= (state_d == S_IDLE) && (credit_d == '0);
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        bet_type_q   <= bus.bet_type;
                        bet_pos_q    <= bus.bet_pos;
                        stake_q      <= bus.bet_amount;
                        win_q        <= 1'b0;
                        win_amount_q <= '0;
                        spin_req_q   <= 1'b1;
                    end else if (bus.bet_valid) begin
                        bet_reject_q <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (bus.spin_done) shown_pos_q <= bus.result_pos;
                end
                S_SETTLE: begin
                    win_q          <= hit;
                    win_amount_q   <= hit ? payout : '0;
                    result_valid_q <= 1'b1;
                    hold_cnt_q     <= '0;
                end
                S_SHOW: begin
                    hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.spin_req     = spin_req_q;
    assign bus.bet_reject   = bet_reject_q;
    assign bus.bet_locked   = bet_locked_q;
    assign bus.credit       = credit_q;
    assign bus.win          = win_q;
    assign bus.win_amount   = win_amount_q;
    assign bus.result_valid = result_valid_q;
    assign bus.shown_pos    = shown_pos_q;
    assign bus.game_over    = game_over_q;
endmodule

// File: tb/tb_roulette_bet_settle.sv
// Bench for roulette_bet_settle: a 16-bit instance for normal play and an 8-bit
// instance for saturation and mid-round reset; settlements go through a scoreboard.
module tb_roulette_bet_settle;
    localparam int SHOW16 = 16;
    localparam int SHOW8  = 4;

    typedef struct {
        int credit;
        int win;
        int win_amount;
        int shown_pos;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    exp_t e16;
    exp_t e8;
    int   checks = 0;
    int   errors = 0;
    int   model16;

    logic clk = 1'b0;
    logic rst16;
    logic rst8;

    always #5 clk = ~clk;

    roulette_bet_settle_if #(.CREDIT_W(16)) b16 ();
    roulette_bet_settle_if #(.CREDIT_W(8))  b8 ();

    roulette_bet_settle #(
        .INIT_CREDIT (100),
        .CREDIT_W    (16),
        .SHOW_CYCLES (SHOW16)
    ) dut16 (
        .clk (clk),
        .rst (rst16),
        .bus (b16)
    );

    roulette_bet_settle #(
        .INIT_CREDIT (250),
        .CREDIT_W    (8),
        .SHOW_CYCLES (SHOW8)
    ) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (b8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Scoreboard: each result_valid pulse consumes one expected settlement.
    always @(negedge clk) begin
        if (b16.result_valid === 1'b1) begin
            if (q16.size() == 0) begin
                check("rv16_unexpected", 32'(b16.result_valid), 32'd0);
            end else begin
                e16 = q16.pop_front();
                check("sb16_credit", 32'(b16.credit), e16.credit);
                check("sb16_win", 32'(b16.win), e16.win);
                check("sb16_win_amount", 32'(b16.win_amount), e16.win_amount);
                check("sb16_shown_pos", 32'(b16.shown_pos), e16.shown_pos);
            end
        end
        if (b8.result_valid === 1'b1) begin
            if (q8.size() == 0) begin
                check("rv8_unexpected", 32'(b8.result_valid), 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("sb8_credit", 32'(b8.credit), e8.credit);
                check("sb8_win", 32'(b8.win), e8.win);
                check("sb8_win_amount", 32'(b8.win_amount), e8.win_amount);
                check("sb8_shown_pos", 32'(b8.shown_pos), e8.shown_pos);
            end
        end
    end

    task automatic round16(input logic t, input logic [2:0] pos, input logic [7:0] amt,
                           input logic [2:0] res);
        logic hit;
        int   pay;
        int   after;
        hit = t ? (res[0] == pos[0]) : (res == pos);
        pay = t ? int'(amt) * 2 : int'(amt) * 8;
        @(negedge clk);
        b16.bet_type   = t;
        b16.bet_pos    = pos;
        b16.bet_amount = amt;
        b16.bet_valid  = 1'b1;
        @(posedge clk); #1;
        b16.bet_valid = 1'b0;
        model16 = model16 - int'(amt);
        check("acc_spin_req", 32'(b16.spin_req), 32'd1);
        check("acc_locked", 32'(b16.bet_locked), 32'd1);
        check("acc_reject", 32'(b16.bet_reject), 32'd0);
        check("acc_credit", 32'(b16.credit), model16);
        check("acc_win_clr", 32'(b16.win), 32'd0);
        check("acc_winamt_clr", 32'(b16.win_amount), 32'd0);
        after = model16 + (hit ? pay : 0);
        if (after > 65535) after = 65535;
        q16.push_back('{after, int'(hit), hit ? pay : 0, int'(res)});
        // A bet while armed must be ignored silently.
        @(negedge clk);
        b16.bet_amount = 8'd1;
        b16.bet_valid  = 1'b1;
        @(posedge clk); #1;
        b16.bet_valid = 1'b0;
        check("armed_spin_req", 32'(b16.spin_req), 32'd0);
        check("armed_reject", 32'(b16.bet_reject), 32'd0);
        check("armed_credit", 32'(b16.credit), model16);
        @(negedge clk);
        b16.result_pos = res;
        b16.spin_done  = 1'b1;
        @(posedge clk); #1;
        b16.spin_done = 1'b0;
        check("settle_shown_pos", 32'(b16.shown_pos), 32'(res));
        check("settle_rv_early", 32'(b16.result_valid), 32'd0);
        @(posedge clk); #1;
        model16 = after;
        check("show_rv", 32'(b16.result_valid), 32'd1);
        check("show_credit", 32'(b16.credit), model16);
        // Stray bet and spin_done while showing.
        @(negedge clk);
        b16.bet_valid  = 1'b1;
        b16.spin_done  = 1'b1;
        b16.result_pos = ~res;
        @(posedge clk); #1;
        b16.bet_valid = 1'b0;
        b16.spin_done = 1'b0;
        check("show_rv_once", 32'(b16.result_valid), 32'd0);
        check("show_reject", 32'(b16.bet_reject), 32'd0);
        check("show_shown_pos", 32'(b16.shown_pos), 32'(res));
        repeat (SHOW16 - 2) @(posedge clk);
        #1;
        check("show_locked_end", 32'(b16.bet_locked), 32'd1);
        @(posedge clk); #1;
        check("idle_locked", 32'(b16.bet_locked), 32'd0);
        check("idle_credit", 32'(b16.credit), model16);
        check("idle_game_over", 32'(b16.game_over), 32'(model16 == 0));
        $display("round type=%0d pos=%0d amt=%0d res=%0d hit=%0d credit=%0d",
                 t, pos, amt, res, hit, model16);
    endtask

    task automatic reject16(input logic [7:0] amt);
        @(negedge clk);
        b16.bet_type   = 1'b0;
        b16.bet_pos    = 3'd0;
        b16.bet_amount = amt;
        b16.bet_valid  = 1'b1;
        @(posedge clk); #1;
        b16.bet_valid = 1'b0;
        check("rej_pulse", 32'(b16.bet_reject), 32'd1);
        check("rej_spin_req", 32'(b16.spin_req), 32'd0);
        check("rej_credit", 32'(b16.credit), model16);
        check("rej_locked", 32'(b16.bet_locked), 32'd0);
        @(posedge clk); #1;
        check("rej_pulse_end", 32'(b16.bet_reject), 32'd0);
        $display("reject amt=%0d credit=%0d", amt, model16);
    endtask

    initial begin
        b16.bet_valid = 1'b0; b16.bet_type = 1'b0; b16.bet_pos = '0;
        b16.bet_amount = '0;  b16.result_pos = '0; b16.spin_done = 1'b0;
        b8.bet_valid = 1'b0;  b8.bet_type = 1'b0;  b8.bet_pos = '0;
        b8.bet_amount = '0;   b8.result_pos = '0;  b8.spin_done = 1'b0;
        rst16 = 1'b1;
        rst8  = 1'b1;
        model16 = 100;
        repeat (3) @(posedge clk);
        #1;
        check("rst_credit16", 32'(b16.credit), 32'd100);
        check("rst_credit8", 32'(b8.credit), 32'd250);
        @(negedge clk);
        rst16 = 1'b0;
        rst8  = 1'b0;
        @(posedge clk); #1;
        check("rst_credit16_run", 32'(b16.credit), 32'd100);
        check("rst_win_amount", 32'(b16.win_amount), 32'd0);
        check("rst_shown_pos", 32'(b16.shown_pos), 32'd0);
        check("rst_locked", 32'(b16.bet_locked), 32'd0);
        check("rst_game_over", 32'(b16.game_over), 32'd0);
        check("rst_spin_req", 32'(b16.spin_req), 32'd0);
        check("rst_rv", 32'(b16.result_valid), 32'd0);

        round16(1'b0, 3'd3, 8'd10, 3'd3);
        round16(1'b1, 3'd1, 8'd20, 3'd4);

        // spin_done while idle must not settle anything.
        @(negedge clk);
        b16.result_pos = 3'd6;
        b16.spin_done  = 1'b1;
        @(posedge clk); #1;
        b16.spin_done = 1'b0;
        check("idle_spin_locked", 32'(b16.bet_locked), 32'd0);
        @(posedge clk); #1;
        check("idle_spin_rv", 32'(b16.result_valid), 32'd0);
        check("idle_spin_credit", 32'(b16.credit), model16);
        $display("stray spin_done in idle credit=%0d", model16);

        reject16(8'd0);
        reject16(8'(model16 + 1));

        round16(1'b0, 3'd0, 8'(model16), 3'd1);
        reject16(8'd1);
        check("go_hold", 32'(b16.game_over), 32'd1);

        // Saturation on the narrow instance: 245 + 40 clamps to 255.
        @(negedge clk);
        b8.bet_type   = 1'b0;
        b8.bet_pos    = 3'd5;
        b8.bet_amount = 8'd5;
        b8.bet_valid  = 1'b1;
        @(posedge clk); #1;
        b8.bet_valid = 1'b0;
        check("sat_acc_credit", 32'(b8.credit), 32'd245);
        check("sat_spin_req", 32'(b8.spin_req), 32'd1);
        q8.push_back('{255, 1, 40, 5});
        @(negedge clk);
        b8.result_pos = 3'd5;
        b8.spin_done  = 1'b1;
        @(posedge clk); #1;
        b8.spin_done = 1'b0;
        @(posedge clk); #1;
        check("sat_rv", 32'(b8.result_valid), 32'd1);
        check("sat_credit", 32'(b8.credit), 32'd255);
        repeat (SHOW8) @(posedge clk);
        #1;
        check("sat_idle_locked", 32'(b8.bet_locked), 32'd0);
        $display("saturate bet=5 payout=40 credit=%0d", b8.credit);

        // Reset while armed discards the stake.
        @(negedge clk);
        b8.bet_pos    = 3'd0;
        b8.bet_amount = 8'd10;
        b8.bet_valid  = 1'b1;
        @(posedge clk); #1;
        b8.bet_valid = 1'b0;
        check("mid_acc_credit", 32'(b8.credit), 32'd245);
        check("mid_acc_locked", 32'(b8.bet_locked), 32'd1);
        @(negedge clk);
        rst8 = 1'b1;
        #1;
        check("mid_rst_credit", 32'(b8.credit), 32'd250);
        check("mid_rst_locked", 32'(b8.bet_locked), 32'd0);
        check("mid_rst_spin_req", 32'(b8.spin_req), 32'd0);
        check("mid_rst_win", 32'(b8.win), 32'd0);
        check("mid_rst_shown", 32'(b8.shown_pos), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst8 = 1'b0;
        b8.result_pos = 3'd0;
        b8.spin_done  = 1'b1;
        @(posedge clk); #1;
        b8.spin_done = 1'b0;
        check("post_rst_rv", 32'(b8.result_valid), 32'd0);
        check("post_rst_spin_req", 32'(b8.spin_req), 32'd0);
        check("post_rst_reject", 32'(b8.bet_reject), 32'd0);
        check("post_rst_locked", 32'(b8.bet_locked), 32'd0);
        @(posedge clk); #1;
        check("post_rst_rv2", 32'(b8.result_valid), 32'd0);
        check("post_rst_credit", 32'(b8.credit), 32'd250);
        $display("reset in armed credit=%0d", b8.credit);

        check("sb16_drained", 32'(q16.size()), 32'd0);
        check("sb8_drained", 32'(q8.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
